subtractor_seq: RTL

- Multi-cycle chunked subtractor that computes a − b over WIDTH-bit unsigned operands, CHUNK bits per clock.
- Inverse-direction companion to the registered adder benchmark family in the arithmetic generated-circuit set; it exercises carry/borrow chains split across cycles.
- Ready/valid on both sides, so it can sit between registered operand sources and result sinks in the benchmark harness.

---
 rtl/subtractor_seq_if.sv | 44 ++++
 rtl/subtractor_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/subtractor_seq_if.sv
// -----------------------------------------------------------------------------
// subtractor_seq_if
//   Ready/valid bundle for the chunked subtractor.
//
//   Operand side : in_valid, in_ready, a[WIDTH-1:0], b[WIDTH-1:0]
//   Result side  : out_valid, out_ready, diff[WIDTH:0] = {borrow, a-b mod 2^WIDTH}
//   Optional     : eq, lt (present only when SUB_CMP_FLAGS_EN is defined)
//
//   modport slave  : the subtractor itself
//   modport master : whatever drives operands and sinks results
// -----------------------------------------------------------------------------
interface subtractor_seq_if #(
  parameter int WIDTH = 66
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;
`ifdef SUB_CMP_FLAGS_EN
  logic             eq;
  logic             lt;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, eq, lt
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, eq, lt
  );
`else
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff
  );
`endif
endinterface

// File: rtl/subtractor_seq.sv
// -----------------------------------------------------------------------------
// subtractor_seq
//   Multi-cycle subtractor: diff = a - b over WIDTH-bit unsigned operands,
//   computed CHUNK bits per clock, borrow carried between cycles.
//
//   Ports
//     clk      : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     bus      : subtractor_seq_if.slave (in_valid/in_ready/a/b,
//                out_valid/out_ready/diff, and eq/lt when enabled)
//
//   Optional feature macro: SUB_CMP_FLAGS_EN
//     Adds registered eq (low WIDTH bits of diff all zero) and lt (= borrow)
//     outputs, valid together with out_valid.
//
//   Flow: IDLE accepts an operand pair, BUSY spends NCHUNK cycles producing
//   one chunk each, DONE holds the result until the sink takes it.
// -----------------------------------------------------------------------------
module subtractor_seq #(
  parameter int WIDTH = 66,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  subtractor_seq_if.slave  bus
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  // Number of real (non-padding) bits in the top chunk.
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OFFW   = $clog2(PADW) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    chunk_q;
  logic             borrow_q;
  logic [WIDTH:0]   diff_q, diff_d;

  logic             in_ready_c, out_valid_c;
  logic             accept, step, last;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    last        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (chunk_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Chunk datapath
  // ---------------------------------------------------------------------------
  logic [PADW-1:0]  a_pad, b_pad;
  logic [OFFW-1:0]  offs;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   sub_full;
  logic             chunk_borrow;

  assign a_pad   = PADW'(a_q);
  assign b_pad   = PADW'(b_q);
  assign offs    = OFFW'(chunk_q) * OFFW'(CHUNK);
  assign a_chunk = a_pad[offs +: CHUNK];
  assign b_chunk = b_pad[offs +: CHUNK];
  assign sub_full = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK + 1)'(borrow_q);

  // In the top chunk the operands are zero-padded above bit LASTW-1, so the
  // borrow out of bit WIDTH-1 appears at sub_full[LASTW]; taking it there keeps
  // the padding from ever influencing the sign bit.
  assign chunk_borrow = last ? sub_full[LASTW] : sub_full[CHUNK];

  // Per-chunk next-value slices of diff; only the chunk being computed moves.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    localparam int LO = gi * CHUNK;
    localparam int SW = (gi == NCHUNK - 1) ? LASTW : CHUNK;
    assign diff_d[LO +: SW] = (step && (chunk_q == CW'(gi))) ? sub_full[SW-1:0]
                                                             : diff_q[LO +: SW];
  end
  assign diff_d[WIDTH] = last ? chunk_borrow : diff_q[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      chunk_q  <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
    end else begin
      diff_q <= diff_d;
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        chunk_q  <= '0;
        borrow_q <= 1'b0;
      end else if (step) begin
        borrow_q <= chunk_borrow;
        chunk_q  <= last ? '0 : chunk_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;

`ifdef SUB_CMP_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Compare flags, folded into the chunk loop so they land with the result.
  // ---------------------------------------------------------------------------
  localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

  logic zero_acc_q;
  logic eq_q, lt_q;
  logic chunk_zero;

  assign chunk_zero = ((sub_full[CHUNK-1:0] & (last ? LAST_MASK : {CHUNK{1'b1}}))
                       == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_acc_q <= 1'b1;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else if (accept) begin
      zero_acc_q <= 1'b1;
    end else if (step) begin
      zero_acc_q <= zero_acc_q & chunk_zero;
      if (last) begin
        eq_q <= zero_acc_q & chunk_zero;
        lt_q <= chunk_borrow;
      end
    end
  end

  assign bus.eq = eq_q;
  assign bus.lt = lt_q;
`endif

endmodule
